// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : RAW hazard stall and taken-branch flush control for a 5-stage
//            pipeline, with saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int RADDR_W   = 6,
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic               id_use_rs,
   input  logic               id_use_rt,
   input  logic               id_wr,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic               ex_br_taken,
   output logic               pc_hold,
   output logic               ifid_hold,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   localparam logic [RADDR_W-1:0] c_zero_reg = '0;
   localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
   localparam logic               c_chk_wb   = ~WB_BYPASS;

   logic               r_ex_v, r_mem_v, r_wb_v;
   logic [RADDR_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
   logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

   logic w_match_rs, w_match_rt;
   logic w_stall, w_flush, w_issue_v;

   // Register 0 never matches, even if a stale entry somehow carried it.
   always_comb begin
      w_match_rs = (id_rs != c_zero_reg) &&
                   ((r_ex_v  && (r_ex_rd  == id_rs)) ||
                    (r_mem_v && (r_mem_rd == id_rs)) ||
                    (c_chk_wb && r_wb_v && (r_wb_rd == id_rs)));
      w_match_rt = (id_rt != c_zero_reg) &&
                   ((r_ex_v  && (r_ex_rd  == id_rt)) ||
                    (r_mem_v && (r_mem_rd == id_rt)) ||
                    (c_chk_wb && r_wb_v && (r_wb_rd == id_rt)));
   end

   always_comb begin
      w_stall   = id_valid & ((id_use_rs & w_match_rs) | (id_use_rt & w_match_rt));
      w_flush   = ex_br_taken;
      w_issue_v = id_valid & id_wr & (id_rd != c_zero_reg) & ~w_stall & ~w_flush;
   end

   // Flush takes priority: the stalled ID instruction is discarded anyway.
   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (w_flush) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (w_stall) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ex_v   <= 1'b0;
         r_mem_v  <= 1'b0;
         r_wb_v   <= 1'b0;
         r_ex_rd  <= '0;
         r_mem_rd <= '0;
         r_wb_rd  <= '0;
      end else begin
         r_wb_v   <= r_mem_v;
         r_wb_rd  <= r_mem_rd;
         r_mem_v  <= r_ex_v;
         r_mem_rd <= r_ex_rd;
         r_ex_v   <= w_issue_v;
         r_ex_rd  <= id_rd;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && !w_flush && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != c_cnt_max))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline; it drives the hold, bubble and flush controls of the PC, IF/ID and ID/EX pipeline registers. It keeps a 3-entry destination-register scoreboard for EX, MEM and WB. From it the block detects read-after-write hazards for the instruction in ID, stalls fetch/decode and inserts bubbles into ID/EX. It also flushes wrong-path instructions when a branch resolves taken in EX, and counts stall and flush cycles for performance debug.

## Interface
Parameters:
- RADDR_W, 6, register address width (matches the 6-bit Rd field carried through ID/EX)
- WB_BYPASS, 1, 1 = register file is write-before-read, so WB-stage destinations never cause a hazard; 0 = WB also checked
- CNT_W, 16, width of the performance counters

Ports:
- clock  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  RADDR_W  first source register of ID instruction
- id_rt  in  RADDR_W  second source register of ID instruction
- id_use_rs  in  1  ID instruction reads id_rs
- id_use_rt  in  1  ID instruction reads id_rt
- id_wr  in  1  ID instruction writes a register
- id_rd  in  RADDR_W  destination register of ID instruction
- ex_br_taken  in  1  branch in EX resolved taken this cycle
- pc_hold  out  1  PC must not update this cycle
- ifid_hold  out  1  IF/ID must retain its contents
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP (EX/MEM control fields zero)
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of taken-branch flushes

## Operation
- Scoreboard: entries SB_EX, SB_MEM, SB_WB, each {v, rd}. Every clock: SB_WB <= SB_MEM; SB_MEM <= SB_EX; SB_EX <= issue entry.
- Issue entry = {id_valid & id_wr & (id_rd != 0), id_rd} when neither stalling nor flushing; otherwise {0, x}.
- Match(r) = r != 0 and a valid entry in SB_EX or SB_MEM has rd == r; if WB_BYPASS=0, SB_WB is also checked.
- stall = id_valid & ((id_use_rs & Match(id_rs)) | (id_use_rt & Match(id_rt))).
- flush = ex_br_taken.
- Priority: flush over stall.
  - flush: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0.
  - stall without flush: pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - Otherwise all four outputs are 0.
- Register 0 is hardwired zero: it is never entered as valid and never matches.
- stall_cnt increments on each cycle with stall & ~flush. flush_cnt increments on each cycle with flush. Both saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Control outputs are combinational from registered scoreboard and current id_*/ex_br_taken inputs (same-cycle, ahead of the clock edge the pipeline registers sample on). No latched outputs.
- Scoreboard and counters are registered, with 1-cycle update.
- Stall length: dependent on an EX-stage producer, 2 cycles (WB_BYPASS=1) or 3 cycles (WB_BYPASS=0); on a MEM-stage producer, 1 or 2 respectively.
- Stall releases automatically as bubbles shift the producer out; no external acknowledge.
- Reset, asserted at any time, including mid-stall: all scoreboard v=0 and counters=0 immediately. Control outputs then follow the combinational rules above, so they are 0 unless ex_br_taken=1.
- Simultaneous stall and ex_br_taken: flush wins and the stalled ID instruction is discarded. stall_cnt does not increment and flush_cnt does.
- id_valid=0: no stall regardless of id_rs/id_rt, and a bubble enters SB_EX.

## Test plan
- Reset then id_valid=0 for 3 cycles -> all control outputs 0, stall_cnt=0, flush_cnt=0.
- Issue write r5, then next cycle ID reads rs=r5 (WB_BYPASS=1) -> pc_hold/ifid_hold/idex_bubble high exactly 2 cycles, released on 3rd; stall_cnt=2.
- Issue write r5, one independent instruction, then ID reads rt=r5 -> 1 stall cycle; with WB_BYPASS=0 -> 2 stall cycles.
- Write r0 followed by read r0 -> no stall; write r7, read r7 with id_use_rs=0/id_use_rt=0 -> no stall.
- Stall in progress with ex_br_taken=1 -> ifid_flush=1, idex_bubble=1, pc_hold=0 that cycle; flush_cnt=1, stall_cnt unchanged.
- Assert reset mid-stall for one cycle -> stall drops the same cycle, counters read 0. Preload counters to max (CNT_W=4, 16 stall cycles) -> stall_cnt holds 15.
